// File: rtl/otter_iobus_timer.sv
// rtl/otter_iobus_timer.sv - IOBUS timer/compare peripheral for the OTTER CPU
// Prescaled 32-bit up-counter with a sticky compare match and a level interrupt.
module otter_iobus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
  parameter int          PRE_W     = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        SEL,
  output logic        INTR
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_COUNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  logic             en;
  logic             auto_rl;
  logic             ie;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pcnt;
  logic [31:0]      compare;
  logic [31:0]      count;
  logic             match;

  logic       hit;
  logic [2:0] off;
  logic       wr_hit;
  logic       wr_ctrl;
  logic       wr_prescale;
  logic       wr_compare;
  logic       wr_count;
  logic       wr_status;
  logic       tick;
  logic       cnt_eq;
  logic       unused_bits;

  assign hit         = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign SEL         = hit;
  assign off         = IOBUS_ADDR[4:2];
  assign wr_hit      = IOBUS_WR & hit;
  assign wr_ctrl     = wr_hit & (off == OFF_CTRL);
  assign wr_prescale = wr_hit & (off == OFF_PRESCALE);
  assign wr_compare  = wr_hit & (off == OFF_COMPARE);
  assign wr_count    = wr_hit & (off == OFF_COUNT);
  assign wr_status   = wr_hit & (off == OFF_STATUS);
  assign unused_bits = ^IOBUS_ADDR[1:0];

  assign tick   = en & (pcnt == prescale);
  assign cnt_eq = (count == compare);

  // Interrupt is purely a function of state, so it clears with the async reset.
  assign INTR = match & ie;

  always_comb begin
    IOBUS_IN = 32'd0;
    if (hit) begin
      case (off)
        OFF_CTRL:     IOBUS_IN = {29'd0, ie, auto_rl, en};
        OFF_PRESCALE: IOBUS_IN = {{(32-PRE_W){1'b0}}, prescale};
        OFF_COMPARE:  IOBUS_IN = compare;
        OFF_COUNT:    IOBUS_IN = count;
        OFF_STATUS:   IOBUS_IN = {31'd0, match};
        default:      IOBUS_IN = 32'd0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
      pcnt     <= '0;
      compare  <= 32'd0;
      count    <= 32'd0;
      match    <= 1'b0;
    end else begin
      if (wr_ctrl || wr_prescale || !en || tick)
        pcnt <= '0;
      else
        pcnt <= pcnt + 1'b1;

      // A CPU write to CTRL overrides the one-shot auto-disable.
      if (wr_ctrl) begin
        en      <= IOBUS_OUT[0];
        auto_rl <= IOBUS_OUT[1];
        ie      <= IOBUS_OUT[2];
      end else if (tick && cnt_eq && !auto_rl && !wr_count) begin
        en <= 1'b0;
      end

      if (wr_prescale)
        prescale <= IOBUS_OUT[PRE_W-1:0];

      if (wr_compare)
        compare <= IOBUS_OUT;

      // A COUNT write discards whatever the coincident tick would have done.
      if (wr_count) begin
        count <= IOBUS_OUT;
      end else if (tick) begin
        if (cnt_eq) begin
          if (auto_rl)
            count <= 32'd0;
        end else begin
          count <= count + 32'd1;
        end
      end

      if (tick && cnt_eq && !wr_count)
        match <= 1'b1;
      else if (wr_status && IOBUS_OUT[0])
        match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_otter_iobus_timer.sv
// tb/tb_otter_iobus_timer.sv - directed scoreboard bench for otter_iobus_timer
module tb_otter_iobus_timer;

  localparam logic [31:0] BASE  = 32'h1100_0100;
  localparam logic [31:0] A_CTL = BASE + 32'h00;
  localparam logic [31:0] A_PRE = BASE + 32'h04;
  localparam logic [31:0] A_CMP = BASE + 32'h08;
  localparam logic [31:0] A_CNT = BASE + 32'h0C;
  localparam logic [31:0] A_STA = BASE + 32'h10;
  localparam logic [31:0] A_RSV = BASE + 32'h14;

  logic        CLK;
  logic        RESET;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic        SEL;
  logic        INTR;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   compared;
  int   mismatched;

  otter_iobus_timer #(.BASE_ADDR(BASE), .PRE_W(16)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR),
    .IOBUS_IN(IOBUS_IN),
    .SEL(SEL),
    .INTR(INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL sb_empty: observed %h expected <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = 32'h0;
    IOBUS_OUT  = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    IOBUS_ADDR = a;
    #1;
    d = IOBUS_IN;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] e;
    compared   = 0;
    mismatched = 0;
    RESET      = 1'b1;
    IOBUS_ADDR = 32'h0;
    IOBUS_OUT  = 32'h0;
    IOBUS_WR   = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Reset state across the whole window, then just past it
    for (int i = 0; i < 8; i++) begin
      rd(BASE + 32'(i * 4), d);
      push($sformatf("rst_read_%0d", i), 32'h0);
      chk(d);
      push($sformatf("rst_sel_%0d", i), 32'h1);
      chk({31'd0, SEL});
    end
    push("rst_intr", 32'h0);
    chk({31'd0, INTR});
    rd(BASE + 32'h20, d);
    push("miss_sel", 32'h0);
    chk({31'd0, SEL});
    push("miss_data", 32'h0);
    chk(d);

    // Auto-reload free run
    wr(A_PRE, 32'd0);
    wr(A_CMP, 32'd3);
    wr(A_CNT, 32'd0);
    wr(A_CTL, 32'h3);
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      rd(A_CNT, d);
      push($sformatf("auto_cnt_c%0d", k), (k <= 4) ? 32'(k - 1) : 32'(k - 5));
      chk(d);
      rd(A_STA, d);
      push($sformatf("auto_sta_c%0d", k), (k >= 5) ? 32'h1 : 32'h0);
      chk(d);
    end
    push("auto_intr_ie0", 32'h0);
    chk({31'd0, INTR});

    // Prescaled one-shot with interrupt
    wr(A_CTL, 32'h0);
    wr(A_STA, 32'h1);
    wr(A_CNT, 32'd0);
    wr(A_PRE, 32'd4);
    wr(A_CMP, 32'd2);
    wr(A_CTL, 32'h5);
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      rd(A_CNT, d);
      push($sformatf("pre_cnt_c%0d", k), 32'(int'(k > 5) + int'(k > 10)));
      chk(d);
      push($sformatf("pre_intr_c%0d", k), (k >= 16) ? 32'h1 : 32'h0);
      chk({31'd0, INTR});
    end
    rd(A_CTL, d);
    push("pre_ctrl_en_off", 32'h4);
    chk(d);
    repeat (6) @(negedge CLK);
    rd(A_CNT, d);
    push("pre_cnt_hold", 32'd2);
    chk(d);
    wr(A_STA, 32'h1);
    @(negedge CLK);
    push("pre_intr_cleared", 32'h0);
    chk({31'd0, INTR});

    // Wrap-around does not match; the later compare does
    wr(A_CTL, 32'h0);
    wr(A_STA, 32'h1);
    wr(A_PRE, 32'd0);
    wr(A_CMP, 32'd5);
    wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CTL, 32'h1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      e = 32'hFFFF_FFFE + 32'(k - 1);
      if (k == 9) e = 32'd5;
      rd(A_CNT, d);
      push($sformatf("wrap_cnt_c%0d", k), e);
      chk(d);
      rd(A_STA, d);
      push($sformatf("wrap_sta_c%0d", k), (k == 9) ? 32'h1 : 32'h0);
      chk(d);
    end

    // COUNT write on a tick cycle wins over the increment
    wr(A_CTL, 32'h0);
    wr(A_STA, 32'h1);
    wr(A_CMP, 32'hFFFF);
    wr(A_CNT, 32'd0);
    wr(A_CTL, 32'h1);
    repeat (2) @(negedge CLK);
    wr(A_CNT, 32'h100);
    @(negedge CLK);
    rd(A_CNT, d);
    push("coll_cnt_write", 32'h100);
    chk(d);
    @(negedge CLK);
    rd(A_CNT, d);
    push("coll_cnt_next", 32'h101);
    chk(d);

    // STATUS clear landing on the match edge: set wins
    wr(A_CTL, 32'h0);
    wr(A_STA, 32'h1);
    wr(A_CMP, 32'd3);
    wr(A_CNT, 32'd0);
    wr(A_CTL, 32'h1);
    repeat (3) @(negedge CLK);
    wr(A_STA, 32'h1);
    @(negedge CLK);
    rd(A_STA, d);
    push("coll_sta_set_wins", 32'h1);
    chk(d);
    rd(A_CNT, d);
    push("coll_cnt_oneshot", 32'd3);
    chk(d);
    rd(A_CTL, d);
    push("coll_ctrl_en_off", 32'h0);
    chk(d);

    // Reserved and out-of-window writes change nothing
    wr(A_PRE, 32'd7);
    wr(A_CTL, 32'h6);
    wr(A_RSV, 32'hFFFF_FFFF);
    wr(BASE + 32'h28, 32'hAAAA);
    rd(A_CTL, d); push("rsv_ctrl", 32'h6);      chk(d);
    rd(A_PRE, d); push("rsv_pre", 32'd7);       chk(d);
    rd(A_CMP, d); push("rsv_cmp", 32'd3);       chk(d);
    rd(A_CNT, d); push("rsv_cnt", 32'd3);       chk(d);
    rd(A_STA, d); push("rsv_sta", 32'h1);       chk(d);
    rd(A_RSV, d); push("rsv_read", 32'h0);      chk(d);
    push("rsv_intr", 32'h1);
    chk({31'd0, INTR});

    // Async reset between edges while INTR is high
    wr(A_CNT, 32'd7);
    rd(A_CNT, d);
    push("pre_rst_cnt", 32'd7);
    chk(d);
    push("pre_rst_intr", 32'h1);
    chk({31'd0, INTR});
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    push("arst_intr", 32'h0);
    chk({31'd0, INTR});
    rd(A_CNT, d);
    push("arst_cnt", 32'h0);
    chk(d);
    rd(A_CTL, d);
    push("arst_ctrl", 32'h0);
    chk(d);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL sb_leftover: observed %0d expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/otter_iobus_timer.md
Name: otter_iobus_timer

Overview:
- Memory-mapped timer/compare peripheral that sits on the IOBUS as the responder to the OTTER CPU's IOBUS master port.
- It decodes IOBUS_ADDR and IOBUS_WR, accepts write data from the CPU, and returns read data on IOBUS_IN.
- It runs a prescaled 32-bit up-counter with a compare match, and drives the CPU's INTR input when a match occurs.

Parameters:
- BASE_ADDR, 32'h1100_0100: base address of the 32-byte register window. Must be 32-byte aligned.
- PRE_W, 16: width of the prescaler register and the prescaler counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IOBUS_ADDR  in  32  CPU IO address (CPU MEM-stage ALU result).
- IOBUS_OUT  in  32  CPU write data (CPU MEM-stage rs2).
- IOBUS_WR  in  1  CPU IO write strobe; one write per cycle in which it is high.
- IOBUS_IN  out  32  read data returned to the CPU.
- SEL  out  1  address hit; the top level uses it to select this block's IOBUS_IN.
- INTR  out  1  level interrupt request to the CPU.

Behaviour:
- Decode:
  - hit = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]); SEL = hit, combinational.
  - Register offset is IOBUS_ADDR[4:2]; IOBUS_ADDR[1:0] are ignored (word access only).
- Register map:
  - 0x00 CTRL: [0] EN, [1] AUTO, [2] IE; other bits read 0.
  - 0x04 PRESCALE[PRE_W-1:0].
  - 0x08 COMPARE[31:0].
  - 0x0C COUNT[31:0]; a write loads the counter.
  - 0x10 STATUS: [0] MATCH, sticky; writing 1 to bit 0 clears it, writing 0 has no effect.
  - 0x14-0x1C reserved: reads return 0, writes are ignored.
- Reads:
  - IOBUS_IN is combinational from IOBUS_ADDR and current register state. Zero added latency, so the CPU memory block samples it in the same cycle.
  - IOBUS_IN = 0 when hit = 0.
- Writes:
  - Take effect at the rising edge where IOBUS_WR=1 and hit=1.
  - The new value is visible on IOBUS_IN from the next cycle.
- Reset: all registers, the prescaler counter and MATCH are cleared; IOBUS_IN = 0, INTR = 0.
- Prescaler:
  - While EN=1, pcnt increments every cycle.
  - When pcnt == PRESCALE: pcnt <= 0 and tick=1 for that cycle.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=N gives a tick every N+1 cycles.
  - A write to CTRL or PRESCALE clears pcnt.
  - While EN=0, pcnt holds at 0 and no ticks occur.
- Counter, on a tick:
  - If COUNT == COMPARE: MATCH <= 1. Then, if AUTO=1, COUNT <= 0; if AUTO=0 (one-shot), COUNT holds and EN <= 0.
  - Otherwise COUNT <= COUNT + 1. COUNT wraps from 32'hFFFF_FFFF to 0, and the wrap does not set MATCH.
- INTR = MATCH & IE, from registers with no combinational path from inputs. It asserts the cycle after the match edge and stays high until MATCH is cleared or IE=0.
- Simultaneous events:
  - CPU write to COUNT in the same cycle as a tick: the write wins and that tick's increment or match is discarded.
  - CPU write to CTRL in the same cycle as a one-shot match: the written EN wins; MATCH is still set.
  - STATUS clear in the same cycle as a new match: set wins (MATCH stays 1).
  - Write to COMPARE in the same cycle as a tick: the comparison uses the old COMPARE.
- Reset asserted mid-count: immediate asynchronous clear of all state, including INTR.
- No handshake or wait states. Every hit access completes in one cycle.

Test Plan:
- Reset and reads:
  - Stimulus: assert RESET, release it, then read 0x1100_0100 through 0x1100_011C.
  - Required: all reads return 0, INTR=0. SEL=1 for those addresses; SEL=0 and IOBUS_IN=0 at 0x1100_0120.
- Auto-reload free run:
  - Stimulus: PRESCALE=0, COMPARE=3, CTRL=0x3.
  - Required: COUNT reads 1,2,3 on successive cycles, then 0 on the next tick. STATUS=1 after the first match, and INTR=0 because IE=0.
- Prescaled one-shot with interrupt:
  - Stimulus: PRESCALE=4, COMPARE=2, CTRL=0x5.
  - Required: COUNT advances every 5 cycles; the match occurs on the 3rd tick (cycle 15). INTR rises at cycle 16, CTRL reads 0x4 (EN cleared), and COUNT holds at 2.
  - Follow-up: write STATUS=1 -> INTR drops the next cycle.
- Wrap-around:
  - Stimulus: COUNT=32'hFFFF_FFFE, COMPARE=5, CTRL=0x1, PRESCALE=0.
  - Required: COUNT reads FFFF_FFFF, then 0, with MATCH still 0. MATCH is set when COUNT hits 5.
- Collisions:
  - COUNT write of 0x100 on a tick cycle -> COUNT reads 0x100, not incremented.
  - STATUS clear coinciding with a match -> MATCH=1.
  - Write to a reserved offset (0x14) -> no state change.
- Async reset mid-run:
  - Stimulus: assert RESET between clock edges while INTR=1 and COUNT=7.
  - Required: INTR, COUNT and CTRL go to 0 before the next edge.
